// File: rtl/task_cmd_issuer.sv
// Task command issuer: buffers host task commands and replays them to the list manager as one-cycle strobes.
// Optional macro TASKCMD_TICKHOLD_EN: hold off new strobes while tick_in is high.
module task_cmd_issuer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MAX_TASKS  = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [2:0]  cmd_op_in,
  input  logic [7:0]  cmd_id_in,
  input  logic [31:0] cmd_addrTCB_in,
  input  logic [5:0]  cmd_priority_in,
  input  logic [31:0] cmd_value_in,
  input  logic        tick_in,
  output logic        createTask_out,
  output logic        suspendTask_out,
  output logic        resumeTask_out,
  output logic        delayTask_out,
  output logic [7:0]  idTask_out,
  output logic [31:0] addrTCB_out,
  output logic [5:0]  priority_out,
  output logic [31:0] valueDelay_out,
  output logic        busy_out,
  output logic        cmd_err_out,
  output logic [15:0] issued_count_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  id;
    logic [31:0] tcb;
    logic [5:0]  pri;
    logic [31:0] value;
  } cmd_t;

  cmd_t             mem [FIFO_DEPTH];
  cmd_t             in_cmd;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [GAP_W-1:0] gap_cnt;
  state_t           state;
  logic             accept;
  logic             cmd_ok;
  logic             push;
  logic             pop;
  logic             issue_ok;
  logic             tick_allow;
  logic             to_idle;

`ifdef TASKCMD_TICKHOLD_EN
  assign tick_allow = !tick_in;
`else
  logic unused_tick;
  assign unused_tick = tick_in;
  assign tick_allow  = 1'b1;
`endif

  // Acceptance, validation and pop decision; pop may start a strobe from IDLE, ISSUE (no gap) or the last GAP cycle.
  always_comb begin
    in_cmd       = '0;
    in_cmd.op    = cmd_op_in[1:0];
    in_cmd.id    = cmd_id_in;
    in_cmd.tcb   = cmd_addrTCB_in;
    in_cmd.pri   = cmd_priority_in;
    in_cmd.value = cmd_value_in;
    cmd_ok   = !cmd_op_in[2] && (32'(cmd_id_in) < MAX_TASKS) &&
               !((cmd_op_in == 3'd3) && (cmd_value_in == 32'd0));
    accept   = cmd_valid_in && cmd_ready_out;
    push     = accept && cmd_ok;
    head     = mem[rd_ptr];
    issue_ok = (count != '0) && tick_allow;
    pop      = 1'b0;
    to_idle  = 1'b0;
    case (state)
      IDLE: begin
        pop     = issue_ok;
        to_idle = !issue_ok;
      end
      ISSUE: begin
        if (GAP_CYCLES == 0) begin
          pop     = issue_ok;
          to_idle = !issue_ok;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          pop     = issue_ok;
          to_idle = !issue_ok;
        end
      end
      default: to_idle = 1'b1;
    endcase
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      gap_cnt          <= '0;
      cmd_ready_out    <= 1'b1;
      cmd_err_out      <= 1'b0;
      busy_out         <= 1'b0;
      createTask_out   <= 1'b0;
      suspendTask_out  <= 1'b0;
      resumeTask_out   <= 1'b0;
      delayTask_out    <= 1'b0;
      idTask_out       <= '0;
      addrTCB_out      <= '0;
      priority_out     <= '0;
      valueDelay_out   <= '0;
      issued_count_out <= '0;
    end else begin
      wr_ptr          <= wr_ptr + PTR_W'(push);
      rd_ptr          <= rd_ptr + PTR_W'(pop);
      count           <= count_nxt;
      cmd_ready_out   <= (count_nxt != CNT_W'(FIFO_DEPTH));
      cmd_err_out     <= accept && !cmd_ok;
      busy_out        <= (count_nxt != '0) || !to_idle;
      createTask_out  <= 1'b0;
      suspendTask_out <= 1'b0;
      resumeTask_out  <= 1'b0;
      delayTask_out   <= 1'b0;
      if (state == ISSUE) issued_count_out <= issued_count_out + 16'd1;

      if (pop) begin
        idTask_out     <= head.id;
        addrTCB_out    <= head.tcb;
        priority_out   <= head.pri;
        valueDelay_out <= head.value;
        case (head.op)
          2'd0:    createTask_out  <= 1'b1;
          2'd1:    suspendTask_out <= 1'b1;
          2'd2:    resumeTask_out  <= 1'b1;
          default: delayTask_out   <= 1'b1;
        endcase
        state <= ISSUE;
      end else begin
        case (state)
          ISSUE: begin
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES);
            end else begin
              state <= IDLE;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_W'(1)) state <= IDLE;
            else gap_cnt <= gap_cnt - GAP_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_task_cmd_issuer.sv
// Scoreboard bench for task_cmd_issuer: default instance plus a zero-gap instance.
module tb_task_cmd_issuer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        c_valid, c_ready, tick;
  logic [2:0]  c_op;
  logic [7:0]  c_id;
  logic [31:0] c_tcb, c_val;
  logic [5:0]  c_pri;
  logic        o_create, o_suspend, o_resume, o_delay, o_busy, o_err;
  logic [7:0]  o_id;
  logic [31:0] o_tcb, o_val;
  logic [5:0]  o_pri;
  logic [15:0] o_count;

  logic        z_valid, z_ready;
  logic [2:0]  z_op;
  logic [7:0]  z_id;
  logic [31:0] z_tcb, z_val;
  logic [5:0]  z_pri;
  logic        z_create, z_suspend, z_resume, z_delay, z_busy, z_err;
  logic [7:0]  z_id_o;
  logic [31:0] z_tcb_o, z_val_o;
  logic [5:0]  z_pri_o;
  logic [15:0] z_count;

  always #5 aclk = ~aclk;

  task_cmd_issuer dut (
    .aclk(aclk), .areset(areset), .cmd_valid_in(c_valid), .cmd_ready_out(c_ready),
    .cmd_op_in(c_op), .cmd_id_in(c_id), .cmd_addrTCB_in(c_tcb), .cmd_priority_in(c_pri),
    .cmd_value_in(c_val), .tick_in(tick), .createTask_out(o_create), .suspendTask_out(o_suspend),
    .resumeTask_out(o_resume), .delayTask_out(o_delay), .idTask_out(o_id), .addrTCB_out(o_tcb),
    .priority_out(o_pri), .valueDelay_out(o_val), .busy_out(o_busy), .cmd_err_out(o_err),
    .issued_count_out(o_count)
  );

  task_cmd_issuer #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .MAX_TASKS(16)) dut0 (
    .aclk(aclk), .areset(areset), .cmd_valid_in(z_valid), .cmd_ready_out(z_ready),
    .cmd_op_in(z_op), .cmd_id_in(z_id), .cmd_addrTCB_in(z_tcb), .cmd_priority_in(z_pri),
    .cmd_value_in(z_val), .tick_in(tick), .createTask_out(z_create), .suspendTask_out(z_suspend),
    .resumeTask_out(z_resume), .delayTask_out(z_delay), .idTask_out(z_id_o), .addrTCB_out(z_tcb_o),
    .priority_out(z_pri_o), .valueDelay_out(z_val_o), .busy_out(z_busy), .cmd_err_out(z_err),
    .issued_count_out(z_count)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  id;
    logic [31:0] tcb;
    logic [5:0]  pri;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   strobe_cycs[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_strobe = -1;
  bit   saw_full;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every strobe on the default instance must match the oldest outstanding valid command.
  logic [3:0] mon_s, mon_exp_s;
  exp_t       mon_e;
  always @(negedge aclk) begin
    mon_s = {o_delay, o_resume, o_suspend, o_create};
    if (c_valid && !c_ready) saw_full = 1'b1;
    if (mon_s != 4'd0) begin
      strobe_cycs.push_back(cyc);
      last_strobe = cyc;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'(mon_s), 64'd0);
      end else begin
        mon_e     = sb.pop_front();
        mon_exp_s = 4'b0001 << mon_e.op[1:0];
        check("strobe_kind", 64'(mon_s), 64'(mon_exp_s));
        check("strobe_id", 64'(o_id), 64'(mon_e.id));
        check("strobe_tcb", 64'(o_tcb), 64'(mon_e.tcb));
        check("strobe_pri", 64'(o_pri), 64'(mon_e.pri));
        check("strobe_val", 64'(o_val), 64'(mon_e.val));
      end
    end
  end

  // Drive one command; starts and ends just after a falling edge.
  task automatic send(input logic [2:0] op, input logic [7:0] id, input logic [31:0] tcb,
                      input logic [5:0] pri, input logic [31:0] val, output int acc);
    int   waitc = 0;
    bit   ok;
    exp_t e;
    c_valid = 1'b1; c_op = op; c_id = id; c_tcb = tcb; c_pri = pri; c_val = val;
    while (!c_ready && waitc < 50) begin
      @(negedge aclk);
      waitc++;
    end
    if (!c_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      c_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge aclk);
    @(negedge aclk);
    c_valid = 1'b0;
    acc = cyc;
    ok = (op < 3'd4) && (id < 8'd16) && !((op == 3'd3) && (val == 32'd0));
    check("err_pulse", 64'(o_err), 64'(!ok));
    if (ok) begin
      e.op = op; e.id = id; e.tcb = tcb; e.pri = pri; e.val = val;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_strobes"}, 64'({o_create, o_suspend, o_resume, o_delay}), 64'd0);
    check({tag, "_data"}, 64'({o_id, o_tcb, o_pri, o_val} != '0), 64'd0);
    check({tag, "_ready"}, 64'(c_ready), 64'd1);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_err"}, 64'(o_err), 64'd0);
    check({tag, "_count"}, 64'(o_count), 64'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int exp_lat;
    areset = 1'b1; tick = 1'b0;
    c_valid = 1'b0; c_op = '0; c_id = '0; c_tcb = '0; c_pri = '0; c_val = '0;
    z_valid = 1'b0; z_op = '0; z_id = '0; z_tcb = '0; z_pri = '0; z_val = '0;
    repeat (3) @(negedge aclk);
    check_reset_state("reset");
    areset = 1'b0;
    @(negedge aclk);

    // Single create: strobe one cycle after acceptance, then count = 1.
    send(3'd0, 8'd0, 32'hAAAA_AAAA, 6'd2, 32'd0, acc);
    drain();
    check("create_latency", 64'(last_strobe), 64'(acc + 1));
    @(negedge aclk);
    check("create_one_cycle", 64'(o_create), 64'd0);
    check("create_hold_tcb", 64'(o_tcb), 64'hAAAA_AAAA);
    check("create_count", 64'(o_count), 64'd1);

    // Rejections: bad opcode, id out of range, zero delay.
    send(3'd5, 8'd1, 32'h1, 6'd1, 32'd5, acc);
    send(3'd0, 8'd20, 32'h2, 6'd1, 32'd0, acc);
    send(3'd3, 8'd1, 32'h3, 6'd1, 32'd0, acc);
    @(negedge aclk);
    check("err_drops", 64'(o_err), 64'd0);
    repeat (5) @(negedge aclk);
    check("reject_count", 64'(o_count), 64'd1);
    check("reject_idle", 64'(o_busy), 64'd0);

    // Burst of 8 fills the FIFO; strobes stay in order, one idle cycle apart.
    strobe_cycs.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 8; i++)
      send(3'(i % 4), 8'(i + 3), $urandom(), 6'(i * 5), 32'(i + 1), acc);
    drain();
    @(negedge aclk);
    check("burst_busy_gap", 64'(o_busy), 64'd1);
    @(negedge aclk);
    check("burst_busy_fall", 64'(o_busy), 64'd0);
    check("burst_saw_full", 64'(saw_full), 64'd1);
    check("burst_strobes", 64'(strobe_cycs.size()), 64'd8);
    for (int i = 1; i < strobe_cycs.size(); i++)
      check("burst_spacing", 64'(strobe_cycs[i] - strobe_cycs[i-1]), 64'd2);
    check("burst_count", 64'(o_count), 64'd9);

    // Tick hold: suspend queued while tick high for three cycles.
    tick = 1'b1;
    send(3'd1, 8'd1, 32'h0, 6'd0, 32'd0, acc);
    repeat (2) @(negedge aclk);
    tick = 1'b0;
    drain();
`ifdef TASKCMD_TICKHOLD_EN
    exp_lat = 3;
`else
    exp_lat = 1;
`endif
    check("tick_latency", 64'(last_strobe), 64'(acc + exp_lat));
    repeat (3) @(negedge aclk);

    // Zero-gap instance: resume then delay on consecutive cycles.
    @(negedge aclk);
    z_valid = 1'b1; z_op = 3'd2; z_id = 8'd2; z_tcb = 32'h0; z_pri = 6'd0; z_val = 32'd0;
    check("g0_ready", 64'(z_ready), 64'd1);
    @(negedge aclk);
    z_op = 3'd3; z_val = 32'h10;
    @(negedge aclk);
    z_valid = 1'b0;
    check("g0_resume", 64'({z_create, z_suspend, z_resume, z_delay}), 64'b0010);
    @(negedge aclk);
    check("g0_delay", 64'({z_create, z_suspend, z_resume, z_delay}), 64'b0001);
    check("g0_delay_val", 64'(z_val_o), 64'h10);
    check("g0_delay_id", 64'(z_id_o), 64'd2);
    @(negedge aclk);
    check("g0_done_strobes", 64'({z_create, z_suspend, z_resume, z_delay}), 64'd0);
    check("g0_count", 64'(z_count), 64'd2);
    check("g0_busy", 64'(z_busy), 64'd0);

    // Reset with three commands queued while in the gap.
    for (int i = 0; i < 5; i++)
      send(3'd0, 8'(i), 32'(32'h100 + i), 6'(i), 32'd0, acc);
    check("pre_reset_busy", 64'(o_busy), 64'd1);
    areset = 1'b1;
    sb.delete();
    @(negedge aclk);
    check_reset_state("midreset");
    areset = 1'b0;
    repeat (10) @(negedge aclk);
    check("post_reset_count", 64'(o_count), 64'd0);
    check("post_reset_busy", 64'(o_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
